zion_clr_rsn_reg_slice: RTL and testbench

Two-entry valid/ready register slice (skid buffer) with synchronous active-low reset and synchronous active-high clear. It sits between a producer and a consumer on any streaming datapath. It breaks the combinational path on data/valid and on ready while sustaining one transfer per cycle. Where the plain clearable DFF consumes data unconditionally, this block adds the consumer-side backpressure end of the link.

---
 rtl/zion_reg_slice_pkg.sv | 16 +
 rtl/zion_reg_slice_ctrl.sv | 72 +++++++
 rtl/zion_clr_rsn_reg_slice.sv | 62 ++++++
 tb/tb_zion_clr_rsn_reg_slice.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/zion_reg_slice_pkg.sv
// rtl/zion_reg_slice_pkg.sv - shared occupancy encodings for valid/ready register slices
package zion_reg_slice_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int SLICE_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        FULL  = ST_FULL
    } slice_state_e;

endpackage

// File: rtl/zion_reg_slice_ctrl.sv
// rtl/zion_reg_slice_ctrl.sv - occupancy FSM and load-enable generation for the two-entry slice
module zion_reg_slice_ctrl
    import zion_reg_slice_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic in_vld_i,
    input  logic out_rdy_i,
    output logic vld_o,
    output logic rdy_o,
    output logic load_main_o,
    output logic main_from_skid_o,
    output logic load_skid_o
);

    slice_state_e state_q;
    slice_state_e state_d;
    logic         in_fire;
    logic         out_fire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else if (clr_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshakes are gated by clear/reset so nothing transfers during a flush.
    assign vld_o    = (state_q != EMPTY) & ~clr_i & rst;
    assign rdy_o    = (state_q != FULL) & ~clr_i & rst;
    assign in_fire  = in_vld_i & rdy_o;
    assign out_fire = vld_o & out_rdy_i;

    always_comb begin
        state_d          = state_q;
        load_main_o      = 1'b0;
        main_from_skid_o = 1'b0;
        load_skid_o      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    load_main_o = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_o = 1'b1;
                end else if (in_fire) begin
                    state_d     = FULL;
                    load_skid_o = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d          = ONE;
                    main_from_skid_o = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/zion_clr_rsn_reg_slice.sv
// rtl/zion_clr_rsn_reg_slice.sv - two-entry skid-buffer register slice with sync reset and clear
module zion_clr_rsn_reg_slice
    import zion_reg_slice_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
);

    if (WIDTH < 1) begin : g_bad_width
        $error("zion_clr_rsn_reg_slice: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] main_dat_q;
    logic [WIDTH-1:0] skid_dat_q;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    zion_reg_slice_ctrl u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .clr_i            (iClr),
        .in_vld_i         (iVld),
        .out_rdy_i        (iRdy),
        .vld_o            (oVld),
        .rdy_o            (oRdy),
        .load_main_o      (load_main),
        .main_from_skid_o (main_from_skid),
        .load_skid_o      (load_skid)
    );

    always_ff @(posedge clk) begin
        if (!rst || iClr) begin
            main_dat_q <= INI_DATA;
        end else if (load_main) begin
            main_dat_q <= iDat;
        end else if (main_from_skid) begin
            main_dat_q <= skid_dat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || iClr) begin
            skid_dat_q <= INI_DATA;
        end else if (load_skid) begin
            skid_dat_q <= iDat;
        end
    end

    assign oDat = main_dat_q;

endmodule

// File: tb/tb_zion_clr_rsn_reg_slice.sv
// tb/tb_zion_clr_rsn_reg_slice.sv - scoreboard bench for the two-entry clearable register slice
module tb_zion_clr_rsn_reg_slice;

    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'h5A;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         iClr = 1'b0;
    logic         iVld = 1'b0;
    logic         iRdy = 1'b0;
    logic [W-1:0] iDat = '0;
    logic         oRdy;
    logic         oVld;
    logic [W-1:0] oDat;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    zion_clr_rsn_reg_slice #(.WIDTH(W), .INI_DATA(INI)) dut (
        .clk  (clk),
        .rst  (rst),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: handshake flags follow model occupancy; outgoing words pop the scoreboard.
    always @(negedge clk) begin
        logic ev;
        logic er;
        logic [W-1:0] e;
        ev = (exp_q.size() > 0) && rst && !iClr;
        er = (exp_q.size() < 2) && rst && !iClr;
        chk("oVld", {31'd0, oVld}, {31'd0, ev});
        chk("oRdy", {31'd0, oRdy}, {31'd0, er});
        if (oVld === 1'b1 && iRdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pop_nonempty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("oDat", {24'd0, oDat}, {24'd0, e});
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                         input logic c, input logic rn, output logic fired);
        iVld = v; iDat = d; iRdy = r; iClr = c; rst = rn;
        @(negedge clk);
        fired = iVld & oRdy;
        @(posedge clk);
        if (!rn || c) exp_q.delete();
        else if (fired) exp_q.push_back(d);
        #1;
    endtask

    initial begin
        logic         f;
        logic         have;
        logic [W-1:0] pend;
        int           k;

        @(posedge clk); #1;
        // Reset held with valid asserted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, f);
        chk("reset_oDat", {24'd0, oDat}, {24'd0, INI});
        chk("reset_fire", {31'd0, f}, 32'd0);

        // Back-to-back stream.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, i[7:0], 1'b1, 1'b0, 1'b1, f);
            chk("stream_accept", {31'd0, f}, 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, f);

        // Backpressure: 0x02 goes to skid, 0x03 waits upstream.
        cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, f);
        cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, f);
        chk("bp_skid", {31'd0, f}, 32'd1);
        cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, f);
        chk("bp_block", {31'd0, f}, 32'd0);
        cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, f);
        chk("bp_bubble", {31'd0, f}, 32'd0);
        cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, f);
        chk("bp_accept3", {31'd0, f}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, f);

        // Clear while full.
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, f);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, f);
        cycle(1'b1, 8'hDD, 1'b1, 1'b1, 1'b1, f);
        chk("clr_fire", {31'd0, f}, 32'd0);
        chk("clr_oDat", {24'd0, oDat}, {24'd0, INI});
        cycle(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, f);
        chk("clr_next_accept", {31'd0, f}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, f);

        // Clear together with reset, and clear with both sides ready.
        cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, f);
        cycle(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, f);
        chk("clr_rst_oDat", {24'd0, oDat}, {24'd0, INI});
        cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, f);
        cycle(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, f);
        chk("clr_busy_fire", {31'd0, f}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, f);

        // Random traffic with a producer that holds data until accepted.
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 10000; i++) begin
            logic v;
            logic r;
            logic c;
            if (!have) begin
                pend = W'($urandom);
                have = ($urandom_range(0, 3) != 0);
            end
            v = have;
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 299) == 0);
            cycle(v, pend, r, c, 1'b1, f);
            if (f || c) have = 1'b0;
        end

        // Drain, bounded.
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, f);
            k++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
